// File: rtl/popcount_tree_stage.sv
// Pipelined binary adder tree: reduces N unsigned 2-bit products to one sum.
// Every level is a register stage; a valid flag travels alongside each level.
module popcount_tree_stage #(
    parameter int n_stage = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [2*(2**n_stage)-1:0]   mult_in,
    output logic [n_stage+1:0]          sum_out,
    output logic                        out_valid
);

    localparam int N = 2 ** n_stage;

    // Bit offset of level k inside the flattened tree bus; level i is (N>>i) values of 2+i bits.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) begin
            o += (N >> i) * (2 + i);
        end
        return o;
    endfunction

    localparam int TOT = lvl_off(n_stage + 1);

    wire  [TOT-1:0]   tree_w;
    logic [n_stage:0] v_q;
    logic [n_stage:0] v_d;

    always_comb begin
        v_d = v_q;
        if (en) begin
            v_d = {v_q[n_stage-1:0], in_valid};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k <= n_stage; k++) begin : g_lvl
            localparam int M  = N >> k;
            localparam int W  = 2 + k;
            localparam int CO = lvl_off(k);

            logic [M*W-1:0] d_q;
            logic [M*W-1:0] d_d;
            logic           ld;

            if (k == 0) begin : g_in
                assign d_d = mult_in;
                assign ld  = in_valid;
            end else begin : g_add
                localparam int PO = lvl_off(k - 1);
                localparam int WP = W - 1;

                // Operands are zero-extended by one bit, so a pair sum can never overflow.
                always_comb begin
                    d_d = '0;
                    for (int j = 0; j < M; j++) begin
                        d_d[j*W +: W] = {1'b0, tree_w[PO + (2*j)*WP +: WP]}
                                      + {1'b0, tree_w[PO + (2*j+1)*WP +: WP]};
                    end
                end

                assign ld = v_q[k-1];
            end

            // Data only moves when a real vector arrives; bubbles leave the level untouched.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_q <= '0;
                end else if (en && ld) begin
                    d_q <= d_d;
                end
            end

            assign tree_w[CO +: M*W] = d_q;
        end
    endgenerate

    assign sum_out   = tree_w[lvl_off(n_stage) +: n_stage+2];
    assign out_valid = v_q[n_stage];

endmodule

// File: doc/popcount_tree_stage.md
# popcount_tree_stage

Pipelined adder tree that consumes the per-element 2-bit products of the multiplier stage and reduces them to a single weighted sum per input vector. It sits directly downstream of the multiplier stage and feeds the neuron accumulation/threshold logic. It accepts one vector per clock, with a valid bit carried alongside the data. A global enable freezes the whole pipeline.

## Interface
- n_stage, default 5: log2 of vector length N = 2**n_stage; also the number of adder levels.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- en  in  1  pipeline enable. When low, every pipeline register holds.
- in_valid  in  1  mult_in carries a vector this cycle.
- mult_in  in  2*N  N unsigned 2-bit products; element i at bits [2i+1:2i].
- sum_out  out  n_stage+2  unsigned sum of the N elements of one vector.
- out_valid  out  1  sum_out holds a new result this cycle.

## Operation
- Register levels L0..Ln, where n = n_stage:
  - L0 holds N values of 2 bits, captured from mult_in.
  - Level Lk (k = 1..n) holds N/2**k values of 2+k bits.
  - Value j at Lk = Lk-1[2j] + Lk-1[2j+1], zero-extended by 1 bit, so no overflow is possible.
  - Ln is a single value of n_stage+2 bits and drives sum_out directly.
- Width check: the maximum sum is 3*N, which is below 2**(n_stage+2), so sum_out never wraps.
- Each level has a valid flag v0..vn:
  - v0 captures in_valid.
  - vk captures vk-1.
  - out_valid = vn.
- Register update rule per level, on a rising edge with en=1:
  - The valid flag always loads.
  - The data registers load only if the incoming valid is 1; otherwise they hold their previous value.
- With en=0, all data and valid registers hold, including out_valid and sum_out.
  - A held out_valid=1 represents the same result, not a new one.
  - The downstream consumer shares en, so it also stalls.
- No backpressure other than en. With en=1 the block accepts a vector every cycle.
- Bubbles (in_valid=0) propagate as gaps in out_valid in order. Results are never reordered or merged.
- No state machine. The behaviour is a pure shift pipeline.

## Timing
- Reset (rst_n low, asynchronous):
  - All data registers, all valid flags, sum_out and out_valid go to 0 immediately.
  - They stay 0 while rst_n is low.
- Reset deassertion is synchronised by the system. The first capture occurs on the first rising edge after rst_n is high.
- Latency:
  - A vector sampled with in_valid=1 on edge t (en=1) appears on sum_out with out_valid=1 after edge t+n_stage.
  - That is n_stage+1 register stages, or n_stage+1 cycles of latency.
  - Each cycle of en=0 adds one cycle of latency.
- Throughput: one vector per cycle.
- Reset mid-operation: all in-flight vectors are discarded. No result from before reset ever appears on out_valid afterwards.
- Simultaneous events:
  - Reset dominates en and in_valid.
  - With en=0, in_valid and mult_in are ignored; the vector is not captured.
- The combinational path per level is one (2+k)-bit adder. No path spans more than one level.

## Test plan
All scenarios use n_stage=5 (N=32, sum_out 7 bits, latency 6) unless stated.
- Reset then idle: rst_n low for 3 cycles, then high, with in_valid=0 -> sum_out=0 and out_valid=0 for 20 cycles.
- Single vector: all 32 elements = 2'b01, in_valid pulsed for 1 cycle -> exactly one out_valid pulse 6 cycles later with sum_out=32. Repeat with all elements = 2'b11 -> sum_out=96, the maximum, no wrap.
- Streaming with bubbles:
  - Inputs: back-to-back vectors with sums 0, 1, 17 (elements 0..16 = 01), a bubble, then 64 (all 10).
  - Required: out_valid pattern 1,1,1,0,1 starting 6 cycles after the first input, sums in order 0, 1, 17, 64.
  - During the bubble, sum_out holds 17.
- Stall: during streaming, drop en for 3 cycles -> every result is delayed by exactly 3 cycles, values are unchanged, and out_valid/sum_out are frozen during the stall.
- Reset mid-flight: issue 3 valid vectors, assert rst_n low 2 cycles later -> outputs go to 0 immediately, and no out_valid is seen from those vectors after release.
- Parameter sweep: n_stage=2 (N=4, latency 3) with elements 3, 0, 2, 1 -> sum_out=6 in 4 bits; random compare against a reference sum for 1000 vectors at n_stage=5.
